// File: rtl/sram_mem_responder.sv
// Purpose : responder for pipeline data-memory word requests; each 32-bit word
//           is moved as two sequential 16-bit accesses (low half, then high
//           half) to an external SRAM.
// Latency : a request seen in IDLE (cycle 0) completes with ready high in
//           cycle 2*WAIT_CYCLES+1. With the default WAIT_CYCLES this is cycle 5.
// Backpressure: ready is low while an access is in flight. The pipeline holds
//           mem_r_en/mem_w_en until ready. The operation is latched at IDLE exit.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   mem_r_en, mem_w_en     level read/write request (write wins if both set)
//   addr, write_data       byte address (word aligned) and store value
//   read_data              registered read word, valid from the DONE cycle
//   ready                  no access in progress, or access completes now
//   sram_addr              registered SRAM halfword address
//   sram_dq_out/oe         registered write halfword and its drive enable
//   sram_we_n              active-low SRAM write enable
//   sram_dq_in             SRAM read data, valid while the address is held
module sram_mem_responder #(
  parameter int BIT_NUMBER  = 32,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 2,
  parameter int SRAM_ADDR_W = 18
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_r_en,
  input  logic                   mem_w_en,
  input  logic [BIT_NUMBER-1:0]  addr,
  input  logic [BIT_NUMBER-1:0]  write_data,
  output logic [BIT_NUMBER-1:0]  read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [15:0]            sram_dq_out,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n,
  input  logic [15:0]            sram_dq_in
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic                    is_wr_q;
  logic [BIT_NUMBER-17:0]  wdata_hi_q;
  logic                    req;
  logic                    last;
  logic [SRAM_ADDR_W-2:0]  word_idx;

  assign req = mem_r_en | mem_w_en;

  // Word index relative to BASE_ADDR. Addresses below the base wrap modulo the
  // SRAM size through the truncating cast. The byte offset bits fall out in
  // the shift.
  assign word_idx = (SRAM_ADDR_W-1)'((addr - BIT_NUMBER'(BASE_ADDR)) >> 2);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req)  state_nxt = LOW;
      LOW:  if (last) state_nxt = HIGH;
      HIGH: if (last) state_nxt = DONE;
      DONE:           state_nxt = IDLE;
      default:        state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    last  = (cnt == CNT_LAST);
    ready = ((state == IDLE) && !req) || (state == DONE);
  end

  // Datapath registers. The SRAM strobes are registered, so each one is
  // loaded on the edge that enters the state in which it must be seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      is_wr_q     <= 1'b0;
      wdata_hi_q  <= '0;
      read_data   <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            is_wr_q    <= mem_w_en;
            wdata_hi_q <= write_data[BIT_NUMBER-1:16];
            sram_addr  <= {word_idx, 1'b0};
            cnt        <= '0;
            if (mem_w_en) begin
              sram_dq_out <= write_data[15:0];
              sram_dq_oe  <= 1'b1;
              sram_we_n   <= 1'b0;
            end else begin
              sram_dq_oe  <= 1'b0;
              sram_we_n   <= 1'b1;
            end
          end
        end
        LOW: begin
          if (last) begin
            if (!is_wr_q) read_data[15:0] <= sram_dq_in;
            // High half lives at the odd halfword of the same word.
            sram_addr <= {sram_addr[SRAM_ADDR_W-1:1], 1'b1};
            cnt       <= '0;
            if (is_wr_q) sram_dq_out <= wdata_hi_q[15:0];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HIGH: begin
          if (last) begin
            if (!is_wr_q) read_data[BIT_NUMBER-1:16] <= (BIT_NUMBER-16)'(sram_dq_in);
            sram_we_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
            cnt        <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_mem_responder.sv
module tb_sram_mem_responder;

  localparam int W = 2;  // WAIT_CYCLES of the DUT

  logic        clk;
  logic        rst;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic        sram_we_n;
  logic [15:0] sram_dq_in;

  int vectors     = 0;
  int miscompares = 0;

  // Reference: word-level memory image plus the expected read_data register
  logic [31:0] model [int];
  logic [31:0] exp_rd;

  // External SRAM: 2^18 halfwords, written at the clock edge while strobed
  logic [15:0] sram [0:262143];
  assign sram_dq_in = sram[sram_addr];
  always @(posedge clk) begin
    if (!sram_we_n && sram_dq_oe) sram[sram_addr] <= sram_dq_out;
  end

  sram_mem_responder #(
    .BIT_NUMBER(32), .BASE_ADDR(1024), .WAIT_CYCLES(W), .SRAM_ADDR_W(18)
  ) dut (
    .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .addr(addr), .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_we_n(sram_we_n), .sram_dq_in(sram_dq_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int word_of(input logic [31:0] a);
    logic [31:0] off;
    off = (a - 32'd1024) >> 2;
    return int'(off % 32'd131072);
  endfunction

  function automatic logic [31:0] model_rd(input int idx);
    if (model.exists(idx)) return model[idx];
    return 32'h0;
  endfunction

  // One cycle with no request: the block must be idle and ready
  task automatic idle_cycle();
    @(posedge clk); #1;
    mem_r_en = 1'b0; mem_w_en = 1'b0;
    #1;
    chk("idle_ready", {31'b0, ready}, 32'd1);
    chk("idle_we_n", {31'b0, sram_we_n}, 32'd1);
    chk("idle_oe", {31'b0, sram_dq_oe}, 32'd0);
    chk("idle_rd", read_data, exp_rd);
  endtask

  // Full access starting in an IDLE cycle. scramble changes addr/write_data
  // after launch, drop releases the request mid-access; neither may matter.
  task automatic access(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input bit scramble, input bit drop);
    int  idx;
    int  lim;
    logic [31:0] exp_addr;
    @(posedge clk); #1;
    mem_r_en = r; mem_w_en = w; addr = a; write_data = d;
    #1;
    chk("busy_c0", {31'b0, ready}, 32'd0);
    idx = word_of(a);
    lim = 2 * W + 1;
    for (int c = 1; c <= lim; c++) begin
      @(posedge clk); #1;
      if (scramble && c == 2) begin addr = $urandom; write_data = $urandom; end
      if (drop && c == 3) begin mem_r_en = 1'b0; mem_w_en = 1'b0; end
      #1;
      exp_addr = 32'(idx) * 2 + ((c > W) ? 1 : 0);
      chk("ready", {31'b0, ready}, (c == lim) ? 32'd1 : 32'd0);
      chk("sram_addr", {14'b0, sram_addr}, exp_addr);
      chk("we_n", {31'b0, sram_we_n}, (w && c < lim) ? 32'd0 : 32'd1);
      chk("oe", {31'b0, sram_dq_oe}, (w && c < lim) ? 32'd1 : 32'd0);
      if (w && c < lim)
        chk("dq_out", {16'b0, sram_dq_out}, (c > W) ? {16'b0, d[31:16]} : {16'b0, d[15:0]});
      if (c == lim) begin
        if (w) model[idx] = d;
        else   exp_rd = model_rd(idx);
        chk("read_data", read_data, exp_rd);
      end
    end
  endtask

  initial begin
    rst = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0; addr = '0; write_data = '0;
    exp_rd = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) idle_cycle();

    // Write, read back, both enables (write wins, read_data kept)
    access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 1'b0, 1'b0);
    idle_cycle();
    access(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0, 1'b0);
    chk("rd_deadbeef", read_data, 32'hDEADBEEF);
    idle_cycle();
    access(1'b1, 1'b1, 32'd1024, 32'h12345678, 1'b0, 1'b0);
    idle_cycle();

    // Back-to-back reads at 1024 and 1032: ready pulses in cycles 5 and 11
    access(1'b0, 1'b1, 32'd1032, 32'h0BADF00D, 1'b0, 1'b0);
    idle_cycle();
    access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0, 1'b0);
    chk("b2b_rd0", read_data, 32'h12345678);
    access(1'b1, 1'b0, 32'd1032, 32'h0, 1'b0, 1'b0);
    chk("b2b_rd1", read_data, 32'h0BADF00D);
    idle_cycle();

    // Reset in cycle 3 of a write, request still held
    @(posedge clk); #1;
    mem_w_en = 1'b1; mem_r_en = 1'b0; addr = 32'd1424; write_data = 32'hCAFEF00D;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("rst_pre_we_n", {31'b0, sram_we_n}, 32'd0);
    @(posedge clk); #2;
    chk("rst_we_n", {31'b0, sram_we_n}, 32'd1);
    chk("rst_oe", {31'b0, sram_dq_oe}, 32'd0);
    chk("rst_rd", read_data, 32'h0);
    chk("rst_ready_req", {31'b0, ready}, 32'd0);
    rst = 1'b0; mem_w_en = 1'b0;
    #1 chk("rst_ready_idle", {31'b0, ready}, 32'd1);
    exp_rd = 32'h0;
    idle_cycle();

    // Preload every word the random phase can touch, including wrapped ones
    for (int i = 0; i < 16; i++)
      access(1'b0, 1'b1, 32'd1024 + 32'(4 * i), $urandom, 1'b0, 1'b0);
    access(1'b0, 1'b1, 32'd1020, $urandom, 1'b0, 1'b0);
    access(1'b0, 1'b1, 32'd1016, $urandom, 1'b0, 1'b0);

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      int kind;
      kind = int'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0)
        a = 32'd1020 - 32'(4 * $urandom_range(0, 1));
      else
        a = 32'd1024 + 32'(4 * $urandom_range(0, 15));
      a[1:0] = 2'($urandom);
      access(kind != 1, kind != 0, a, $urandom,
             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      repeat ($urandom_range(0, 2)) idle_cycle();
    end
    idle_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_mem_responder.md
Name: sram_mem_responder

Overview:
- Responder end of the pipeline data-memory interface. Accepts the MEM stage's word read/write requests: mem_r_en, mem_w_en, address and store value.
- Services each request as two sequential 16-bit accesses to an external SRAM.
- Returns a 32-bit read word plus a ready flag. The hazard/freeze logic uses ready to stall the pipeline while an access is in flight.

Parameters:
- BIT_NUMBER, 32, data/address width of the pipeline side.
- BASE_ADDR, 1024, byte address mapped to SRAM word 0.
- WAIT_CYCLES, 2, cycles each 16-bit SRAM half-access is held (≥1).
- SRAM_ADDR_W, 18, SRAM address width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- mem_r_en  input  1  read request, level, held by the pipeline until ready.
- mem_w_en  input  1  write request, level, held until ready.
- addr  input  BIT_NUMBER  byte address (ALU result), word aligned.
- write_data  input  BIT_NUMBER  store value (Rm).
- read_data  output  BIT_NUMBER  registered read word.
- ready  output  1  high = no access in progress, or access completes this cycle.
- sram_addr  output  SRAM_ADDR_W  registered SRAM halfword address.
- sram_dq_out  output  16  registered write halfword.
- sram_dq_oe  output  1  drive enable for sram_dq_out.
- sram_we_n  output  1  active-low SRAM write enable.
- sram_dq_in  input  16  SRAM read data, valid while address is held.

Behaviour:
- Clock/reset: single clock domain; reset is synchronous and active-high.
- Reset values:
  - state = IDLE, phase counter = 0.
  - read_data = 0, sram_addr = 0, sram_dq_out = 0, sram_dq_oe = 0, sram_we_n = 1.
- Address map:
  - word_idx = (addr − BASE_ADDR) >> 2, truncated to SRAM_ADDR_W−1 bits.
  - Low half at sram_addr = {word_idx,0}; high half at {word_idx,1}.
  - Addresses below BASE_ADDR wrap modulo SRAM size; no error flag.
  - addr[1:0] ignored.
- Request decode: req = mem_r_en | mem_w_en. If both are set, the request is a write and read_data is unchanged.
- FSM states: IDLE, LOW, HIGH, DONE.
  - IDLE: if req, latch addr/write_data/kind, load sram_addr = low addr, and go to LOW (counter = 0). Else stay.
  - LOW: held WAIT_CYCLES cycles.
    - Write: sram_dq_out = data[15:0], oe = 1, we_n = 0.
    - Read: oe = 0, we_n = 1.
    - On the last cycle, a read captures sram_dq_in into read_data[15:0]. Next state is HIGH with sram_addr = high addr and counter reset.
  - HIGH: same as LOW, using data[31:16] / read_data[31:16]. Next state is DONE; we_n returns to 1 and oe to 0 on entry to DONE.
  - DONE: one cycle, then IDLE unconditionally.
- ready (combinational) = (state==IDLE & ~req) | (state==DONE).
- Latency: request visible in cycle 0 (IDLE) → ready high in cycle 2·WAIT_CYCLES+1. With defaults, cycle 5.
- read_data: valid from the DONE cycle; holds until the next read completes each half.
- Back-to-back: a request present in the cycle after DONE (IDLE) starts immediately, so ready drops that cycle.
- Request deassertion mid-access is ignored: the latched operation completes.
- rst during any state:
  - Next cycle is IDLE, we_n = 1, oe = 0, and read_data = 0.
  - A partial write may leave the low half written; this is acceptable.
- Latched inputs: request inputs are latched at IDLE exit; later changes to addr/write_data do not affect the in-flight access.

Test Plan:
- Idle: no request after reset → ready = 1, we_n = 1, oe = 0, read_data = 0 for 10 cycles.
- Write: mem_w_en = 1, addr = 1028, write_data = 0xDEADBEEF → cycles 1–2: sram_addr = 2, dq_out = 0xBEEF, we_n = 0. Cycles 3–4: sram_addr = 3, dq_out = 0xDEAD, we_n = 0. Cycle 5: ready = 1, we_n = 1.
- Read: SRAM model preloaded from the write; mem_r_en = 1, addr = 1028 → we_n stays 1, oe = 0. Cycle 5: ready = 1, read_data = 0xDEADBEEF.
- Both enables: mem_r_en = mem_w_en = 1, addr = 1024, write_data = 0x12345678 → write of 0x5678 to addr 0 and 0x1234 to addr 1; read_data unchanged.
- Reset mid-write: assert rst in cycle 3 of a write → next cycle state IDLE, we_n = 1, oe = 0, ready = !req, read_data = 0.
- Back-to-back reads at 1024 then 1032 → ready pulses exactly in cycles 5 and 11. sram_addr sequence is 0, 1, 4, 5; read_data is correct after each pulse.
